pipeline_interlock_scoreboard: RTL and testbench

//  Parametrised successor to the combinational stall logic in the CPU pipeline. Sits between ID and EX.

---
 rtl/pipeline_interlock_scoreboard_pkg.sv | 13 +
 rtl/pipeline_interlock_scoreboard_sat_counter.sv | 27 ++
 rtl/pipeline_interlock_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_pipeline_interlock_scoreboard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_interlock_scoreboard_pkg.sv
// Shared constants for the ID/EX hazard detection unit: stall-cause bit positions and widths.
package hdu_pkg;

    localparam int CAUSE_RAW   = 0;
    localparam int CAUSE_PEND  = 1;
    localparam int CAUSE_NPU   = 2;
    localparam int CAUSE_CACHE = 3;
    localparam int CAUSE_W     = 4;
    localparam int PERF_W      = 32;

    typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/pipeline_interlock_scoreboard_sat_counter.sv
// 32-bit saturating event counter with synchronous clear; only built with HDU_PERF_CNT_EN defined.
`ifdef HDU_PERF_CNT_EN
module hdu_sat_counter #(
    parameter int W = 32
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iClr,
    input  logic         iInc,
    output logic [W-1:0] oCount
);

    // Count events, holding at all-ones; clear takes priority over increment.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oCount <= {W{1'b0}};
        end else if (iClr) begin
            oCount <= {W{1'b0}};
        end else if (iInc && (oCount != {W{1'b1}})) begin
            oCount <= oCount + W'(1);
        end else begin
            oCount <= oCount;
        end
    end

endmodule
`endif

// File: rtl/pipeline_interlock_scoreboard.sv
// ID/EX interlock: per-register busy scoreboard for long-latency ops merged with NPU and cache stalls.
// Optional HDU_PERF_CNT_EN adds four per-cause saturating stall counters readable through iCntSel.
module pipeline_interlock_scoreboard
    import hdu_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int MAX_PENDING  = 4,
    parameter bit HAS_ZERO_REG = 1'b1,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iIdValid,
    input  logic [REG_W-1:0]   iIdRegRs,
    input  logic [REG_W-1:0]   iIdRegRt,
    input  logic               iIdUseRs,
    input  logic               iIdUseRt,
    input  logic [REG_W-1:0]   iIdRegDst,
    input  logic               iIdLongOp,
    input  logic               iIdNpuCfgOp,
    input  logic               iIdNpuEnqOp,
    input  logic               iIdNpuDeqOp,
    input  logic               iNpuConfigFull,
    input  logic               iNpuInputFull,
    input  logic               iNpuOutputEmpty,
    input  logic               iInstrCacheValid,
    input  logic               iInstrCacheReady,
    input  logic               iDataCacheValid,
    input  logic               iDataCacheReady,
    input  logic               iFlush,
    input  logic               iWbValid,
    input  logic [REG_W-1:0]   iWbRegDst,
`ifdef HDU_PERF_CNT_EN
    input  logic               iCntClr,
    input  logic [1:0]         iCntSel,
    output logic [PERF_W-1:0]  oCntData,
`endif
    output logic               oStall,
    output logic [CAUSE_W-1:0] oStallCause,
    output logic               oIssue,
    output logic [CNT_W-1:0]   oPendingCnt,
    output logic               oSbErr
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                err_r;
    logic                err_evt_s;
    cause_t              cause_s;
    logic                set_s;
    logic                dec_s;

    function automatic logic is_zero(input logic [REG_W-1:0] r);
        return HAS_ZERO_REG && (r == {REG_W{1'b0}});
    endfunction

    // A register never hazards if it is the zero register or is being written back this cycle.
    function automatic logic exempt(input logic [REG_W-1:0] r, input logic wb_v,
                                    input logic [REG_W-1:0] wb_r);
        return is_zero(r) || (wb_v && (r == wb_r));
    endfunction

    // Hazard causes, all combinational from current scoreboard state and ID inputs.
    always_comb begin
        cause_s = {CAUSE_W{1'b0}};
        if (iIdValid) begin
            cause_s[CAUSE_RAW] =
                (iIdUseRs  && busy_r[iIdRegRs]  && !exempt(iIdRegRs,  iWbValid, iWbRegDst)) ||
                (iIdUseRt  && busy_r[iIdRegRt]  && !exempt(iIdRegRt,  iWbValid, iWbRegDst)) ||
                (iIdLongOp && busy_r[iIdRegDst] && !exempt(iIdRegDst, iWbValid, iWbRegDst));
            cause_s[CAUSE_PEND] = iIdLongOp && (cnt_r == CNT_W'(MAX_PENDING)) && !iWbValid;
            cause_s[CAUSE_NPU]  = (iIdNpuCfgOp && iNpuConfigFull) ||
                                  (iIdNpuEnqOp && iNpuInputFull)  ||
                                  (iIdNpuDeqOp && iNpuOutputEmpty);
        end else begin
            cause_s[CAUSE_RAW]  = 1'b0;
            cause_s[CAUSE_PEND] = 1'b0;
            cause_s[CAUSE_NPU]  = 1'b0;
        end
        cause_s[CAUSE_CACHE] = (iInstrCacheValid && !iInstrCacheReady) ||
                               (iDataCacheValid  && !iDataCacheReady);
    end

    // Output decode; reset forces a stall with no cause reported.
    always_comb begin
        if (iRst) begin
            oStall      = 1'b1;
            oStallCause = {CAUSE_W{1'b0}};
            oIssue      = 1'b0;
        end else begin
            oStall      = |cause_s;
            oStallCause = cause_s;
            oIssue      = iIdValid && !(|cause_s) && !iFlush;
        end
    end

    // Scoreboard next state: clear on writeback, then set on long-op issue so set wins.
    always_comb begin
        set_s      = oIssue && iIdLongOp;
        dec_s      = iWbValid && (cnt_r != {CNT_W{1'b0}});
        err_evt_s  = iWbValid && ((!busy_r[iWbRegDst] && !is_zero(iWbRegDst)) ||
                                  (cnt_r == {CNT_W{1'b0}}));
        busy_nxt_s = busy_r;
        if (iWbValid) begin
            busy_nxt_s[iWbRegDst] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (set_s && !is_zero(iIdRegDst)) begin
            busy_nxt_s[iIdRegDst] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        case ({set_s, dec_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Scoreboard, pending count and sticky protocol-error registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            busy_r <= {NUM_REGS{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
            err_r  <= err_r || err_evt_s;
        end
    end

    assign oPendingCnt = cnt_r;
    assign oSbErr      = err_r;

`ifdef HDU_PERF_CNT_EN
    logic [PERF_W-1:0] perf_cnt_s [CAUSE_W];

    for (genvar g = 0; g < CAUSE_W; g++) begin : g_perf
        hdu_sat_counter #(.W(PERF_W)) u_cnt (
            .iClk   (iClk),
            .iRst   (iRst),
            .iClr   (iCntClr),
            .iInc   (oStallCause[g]),
            .oCount (perf_cnt_s[g])
        );
    end

    // Counter readback mux.
    always_comb begin
        case (iCntSel)
            2'd0:    oCntData = perf_cnt_s[0];
            2'd1:    oCntData = perf_cnt_s[1];
            2'd2:    oCntData = perf_cnt_s[2];
            2'd3:    oCntData = perf_cnt_s[3];
            default: oCntData = {PERF_W{1'b0}};
        endcase
    end
`endif

endmodule

// File: tb/tb_pipeline_interlock_scoreboard.sv
// Directed bench for pipeline_interlock_scoreboard: a cycle-by-cycle vector table plus hand sequences.
module tb_pipeline_interlock_scoreboard;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iIdValid, iIdUseRs, iIdUseRt, iIdLongOp;
    logic [4:0] iIdRegRs, iIdRegRt, iIdRegDst, iWbRegDst;
    logic       iIdNpuCfgOp, iIdNpuEnqOp, iIdNpuDeqOp;
    logic       iNpuConfigFull, iNpuInputFull, iNpuOutputEmpty;
    logic       iInstrCacheValid, iInstrCacheReady, iDataCacheValid, iDataCacheReady;
    logic       iFlush, iWbValid;
    logic       oStall, oIssue, oSbErr;
    logic [3:0] oStallCause;
    logic [2:0] oPendingCnt;
`ifdef HDU_PERF_CNT_EN
    logic        iCntClr;
    logic [1:0]  iCntSel;
    logic [31:0] oCntData;
`endif

    int tests = 0;
    int fails = 0;

    always #5 iClk = ~iClk;

    pipeline_interlock_scoreboard dut (
        .iClk(iClk), .iRst(iRst), .iIdValid(iIdValid),
        .iIdRegRs(iIdRegRs), .iIdRegRt(iIdRegRt), .iIdUseRs(iIdUseRs), .iIdUseRt(iIdUseRt),
        .iIdRegDst(iIdRegDst), .iIdLongOp(iIdLongOp),
        .iIdNpuCfgOp(iIdNpuCfgOp), .iIdNpuEnqOp(iIdNpuEnqOp), .iIdNpuDeqOp(iIdNpuDeqOp),
        .iNpuConfigFull(iNpuConfigFull), .iNpuInputFull(iNpuInputFull),
        .iNpuOutputEmpty(iNpuOutputEmpty),
        .iInstrCacheValid(iInstrCacheValid), .iInstrCacheReady(iInstrCacheReady),
        .iDataCacheValid(iDataCacheValid), .iDataCacheReady(iDataCacheReady),
        .iFlush(iFlush), .iWbValid(iWbValid), .iWbRegDst(iWbRegDst),
`ifdef HDU_PERF_CNT_EN
        .iCntClr(iCntClr), .iCntSel(iCntSel), .oCntData(oCntData),
`endif
        .oStall(oStall), .oStallCause(oStallCause), .oIssue(oIssue),
        .oPendingCnt(oPendingCnt), .oSbErr(oSbErr)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs;  logic urs;
        logic [4:0] rt;  logic urt;
        logic [4:0] dst; logic lo;
        logic       dq;  logic oe;
        logic       fl;
        logic       wb;  logic [4:0] wd;
        logic       e_stall;
        logic [3:0] e_cause;
        logic       e_issue;
        logic [2:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt,
                                input logic [4:0] dst, input logic lo,
                                input logic dq, input logic oe, input logic fl,
                                input logic wb, input logic [4:0] wd,
                                input logic es, input logic [3:0] ec,
                                input logic ei, input logic [2:0] ecnt);
        vec_t r;
        r = '{v, rs, urs, rt, urt, dst, lo, dq, oe, fl, wb, wd, es, ec, ei, ecnt};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iIdValid = 1'b0; iIdUseRs = 1'b0; iIdUseRt = 1'b0; iIdLongOp = 1'b0;
        iIdRegRs = 5'd0; iIdRegRt = 5'd0; iIdRegDst = 5'd0; iWbRegDst = 5'd0;
        iIdNpuCfgOp = 1'b0; iIdNpuEnqOp = 1'b0; iIdNpuDeqOp = 1'b0;
        iNpuConfigFull = 1'b0; iNpuInputFull = 1'b0; iNpuOutputEmpty = 1'b0;
        iInstrCacheValid = 1'b0; iInstrCacheReady = 1'b0;
        iDataCacheValid = 1'b0; iDataCacheReady = 1'b0;
        iFlush = 1'b0; iWbValid = 1'b0;
`ifdef HDU_PERF_CNT_EN
        iCntClr = 1'b0; iCntSel = 2'd0;
`endif
    endtask

    task automatic next_cycle();
        @(posedge iClk);
        #1;
    endtask

    vec_t vecs [25];

    initial begin
        //         v  rs  urs rt urt dst lo dq oe fl wb wd  | stall cause   issue cnt
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 0);
        vecs[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'b0001, 0, 1);
        vecs[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 4'b0000, 1, 1);
        vecs[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 1);
        vecs[7]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 2);
        vecs[8]  = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 3);
        vecs[9]  = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,  1, 4'b0010, 0, 4);
        vecs[10] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 1,  0, 4'b0000, 1, 4);
        vecs[11] = mk(1, 0, 0, 2, 1, 6, 1, 0, 0, 0, 0, 0,  1, 4'b0011, 0, 4);
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 4'b0100, 0, 4);
        vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 4'b0000, 1, 4);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 4'b0000, 0, 4);
        vecs[15] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 4'b0001, 0, 4);
        vecs[16] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 4'b0000, 0, 4);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 4'b0000, 0, 4);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 4'b0000, 0, 3);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  0, 4'b0000, 0, 2);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,  0, 4'b0000, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'b0000, 0, 0);
        vecs[22] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 0);
        vecs[23] = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 1);
        vecs[24] = mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0,  0, 4'b0000, 1, 2);

        idle_inputs();
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        check("reset_stall", {31'd0, oStall}, 32'd1);
        check("reset_issue", {31'd0, oIssue}, 32'd0);
        check("reset_cause", {28'd0, oStallCause}, 32'd0);
        check("reset_cnt", {29'd0, oPendingCnt}, 32'd0);
        check("reset_err", {31'd0, oSbErr}, 32'd0);
        iRst = 1'b0;
        #1;
        check("post_reset_stall", {31'd0, oStall}, 32'd0);
        next_cycle();

        for (int i = 0; i < 25; i++) begin
            iIdValid = vecs[i].v;
            iIdRegRs = vecs[i].rs;   iIdUseRs = vecs[i].urs;
            iIdRegRt = vecs[i].rt;   iIdUseRt = vecs[i].urt;
            iIdRegDst = vecs[i].dst; iIdLongOp = vecs[i].lo;
            iIdNpuDeqOp = vecs[i].dq; iNpuOutputEmpty = vecs[i].oe;
            iFlush = vecs[i].fl;
            iWbValid = vecs[i].wb;   iWbRegDst = vecs[i].wd;
            #2;
            check($sformatf("row%0d_stall", i), {31'd0, oStall}, {31'd0, vecs[i].e_stall});
            check($sformatf("row%0d_cause", i), {28'd0, oStallCause}, {28'd0, vecs[i].e_cause});
            check($sformatf("row%0d_issue", i), {31'd0, oIssue}, {31'd0, vecs[i].e_issue});
            check($sformatf("row%0d_cnt", i), {29'd0, oPendingCnt}, {29'd0, vecs[i].e_cnt});
            check($sformatf("row%0d_err", i), {31'd0, oSbErr}, 32'd0);
            next_cycle();
        end
        idle_inputs();
        #1;
        check("table_end_cnt", {29'd0, oPendingCnt}, 32'd3);

        // Asynchronous reset mid-flight, with a cache miss and a would-be hazard present.
        iDataCacheValid = 1'b1;
        iIdValid = 1'b1; iIdUseRs = 1'b1; iIdRegRs = 5'd8;
        iRst = 1'b1;
        #1;
        check("midrst_stall", {31'd0, oStall}, 32'd1);
        check("midrst_cause", {28'd0, oStallCause}, 32'd0);
        check("midrst_issue", {31'd0, oIssue}, 32'd0);
        check("midrst_cnt", {29'd0, oPendingCnt}, 32'd0);
        next_cycle();
        iRst = 1'b0;
        idle_inputs();
        #1;
        check("midrst_release_stall", {31'd0, oStall}, 32'd0);
        iIdValid = 1'b1; iIdUseRs = 1'b1; iIdRegRs = 5'd8;
        #1;
        check("midrst_busy_cleared", {31'd0, oStall}, 32'd0);
        check("midrst_issue_after", {31'd0, oIssue}, 32'd1);
        next_cycle();
        idle_inputs();

        // Data cache miss held for three cycles with no instruction in ID.
        iDataCacheValid = 1'b1; iDataCacheReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("cache_c%0d_stall", c), {31'd0, oStall}, 32'd1);
            check($sformatf("cache_c%0d_cause", c), {28'd0, oStallCause}, 32'd8);
            next_cycle();
        end
        iDataCacheReady = 1'b1;
        #1;
        check("cache_ready_stall", {31'd0, oStall}, 32'd0);
`ifdef HDU_PERF_CNT_EN
        iCntSel = 2'd3;
        #1;
        check("perf_cache_cnt", oCntData, 32'd3);
        iCntSel = 2'd0;
        #1;
        check("perf_raw_cnt", oCntData, 32'd0);
        iCntClr = 1'b1; iCntSel = 2'd3;
        next_cycle();
        iCntClr = 1'b0;
        #1;
        check("perf_clr", oCntData, 32'd0);
`endif
        idle_inputs();
        next_cycle();

        // Writeback to a register that is not busy while nothing is pending.
        iWbValid = 1'b1; iWbRegDst = 5'd7;
        #2;
        check("err_before_edge", {31'd0, oSbErr}, 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        check("err_set", {31'd0, oSbErr}, 32'd1);
        check("err_cnt_no_underflow", {29'd0, oPendingCnt}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check($sformatf("err_sticky_c%0d", c), {31'd0, oSbErr}, 32'd1);
        end
        iRst = 1'b1;
        #1;
        check("err_cleared_by_reset", {31'd0, oSbErr}, 32'd0);
        next_cycle();
        iRst = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
